// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes and FSM state encodings shared by the execution ALU and
//            alu_control.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b1000;
  localparam logic [3:0] OP_ADDR  = 4'b1100;
  localparam logic [3:0] OP_PASSB = 4'b1110;
  localparam logic [3:0] OP_CMP   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
// ============================================================================
// Module   : alu_exec_unit_if
// Brief    : Start/done handshake and operand/result bus of the execution ALU.
//            ovfFlag exists only when ALU_OVERFLOW_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       ctrlIn;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] resultHi;
  logic             zeroFlag;
  logic             divByZero;
  logic             illegalOp;
`ifdef ALU_OVERFLOW_EN
  logic             ovfFlag;
`endif

  modport master (
`ifdef ALU_OVERFLOW_EN
    input  ovfFlag,
`endif
    output start, ctrlIn, opA, opB,
    input  busy, done, result, resultHi, zeroFlag, divByZero, illegalOp
  );

  modport slave (
`ifdef ALU_OVERFLOW_EN
    output ovfFlag,
`endif
    input  start, ctrlIn, opA, opB,
    output busy, done, result, resultHi, zeroFlag, divByZero, illegalOp
  );
endinterface

`default_nettype wire

// File: rtl/alu_iter_core.sv
// ============================================================================
// Module   : alu_iter_core
// Brief    : Shared one-bit-per-cycle engine: shift-add multiply or restoring
//            divide over a {hi,lo} register pair.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_iter_core #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             run,
  input  wire logic             mode,     // 1 = DIV, 0 = MUL, sampled on load
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic                  last,
  output logic [WIDTH-1:0]      next_lo,
  output logic [WIDTH-1:0]      next_hi
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic [WIDTH:0]   w_sum, w_shift, w_diff;

  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};
    next_hi = w_sum[WIDTH:1];
    next_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      // Restoring step: keep the trial subtraction only when it did not borrow.
      if (!w_diff[WIDTH]) begin
        next_hi = w_diff[WIDTH-1:0];
        next_lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = w_shift[WIDTH-1:0];
        next_lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
    last = run && (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (load) begin
      r_hi  <= '0;
      r_lo  <= mode ? a : b;
      r_b   <= mode ? b : a;
      r_cnt <= '0;
      r_div <= mode;
    end else if (run) begin
      r_hi  <= next_hi;
      r_lo  <= next_lo;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execution-stage ALU with single-cycle ops and iterative MUL/DIV.
//            Optional signed overflow output under macro ALU_OVERFLOW_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  alu_exec_unit_if.slave bus
);
  alu_state_t       r_state, w_state_nxt;
  logic             w_accept, w_iter_op, w_last;
  logic [WIDTH-1:0] w_sum, w_diff, w_next_lo, w_next_hi;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_zero, r_dbz, r_ill, r_is_mul;

  assign w_sum     = bus.opA + bus.opB;
  assign w_diff    = bus.opA - bus.opB;
  assign w_accept  = bus.start && (r_state == ST_IDLE);
  assign w_iter_op = (bus.ctrlIn == OP_MUL) ||
                     ((bus.ctrlIn == OP_DIV) && (bus.opB != '0));

  alu_iter_core #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (w_accept && w_iter_op),
    .run     (r_state == ST_ITER),
    .mode    (bus.ctrlIn == OP_DIV),
    .a       (bus.opA),
    .b       (bus.opB),
    .last    (w_last),
    .next_lo (w_next_lo),
    .next_hi (w_next_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.busy    = (r_state != ST_IDLE);
    bus.done    = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_iter_op ? ST_ITER : ST_DONE;
      ST_ITER: if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
      r_ill       <= 1'b0;
      r_is_mul    <= 1'b0;
    end else if (w_accept) begin
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
      r_is_mul <= (bus.ctrlIn == OP_MUL);
      case (bus.ctrlIn)
        OP_ADD, OP_ADDR: begin
          r_result    <= w_sum;
          r_result_hi <= '0;
          r_zero      <= (w_sum == '0);
        end
        OP_SUB: begin
          r_result    <= w_diff;
          r_result_hi <= '0;
          r_zero      <= (w_diff == '0);
        end
        OP_PASSB: begin
          r_result    <= bus.opB;
          r_result_hi <= '0;
          r_zero      <= (bus.opB == '0);
        end
        OP_CMP: begin
          r_result    <= '0;
          r_result_hi <= '0;
          r_zero      <= (w_diff == '0);
        end
        OP_MUL: ;  // results land when the iteration finishes
        OP_DIV: begin
          if (bus.opB == '0) begin
            r_result    <= '1;
            r_result_hi <= bus.opA;
            r_zero      <= 1'b0;
            r_dbz       <= 1'b1;
          end
        end
        default: begin
          r_result    <= '0;
          r_result_hi <= '0;
          r_zero      <= 1'b1;
          r_ill       <= 1'b1;
        end
      endcase
    end else if (w_last) begin
      r_result    <= w_next_lo;
      r_result_hi <= w_next_hi;
      r_zero      <= r_is_mul ? ({w_next_hi, w_next_lo} == '0) : (w_next_lo == '0);
    end
  end

  assign bus.result    = r_result;
  assign bus.resultHi  = r_result_hi;
  assign bus.zeroFlag  = r_zero;
  assign bus.divByZero = r_dbz;
  assign bus.illegalOp = r_ill;

`ifdef ALU_OVERFLOW_EN
  logic r_ovf, w_add_ovf, w_sub_ovf;
  // Signed overflow: operands agree (add) / differ (sub) in sign but the result flips.
  assign w_add_ovf = (bus.opA[WIDTH-1] == bus.opB[WIDTH-1]) && (w_sum[WIDTH-1]  != bus.opA[WIDTH-1]);
  assign w_sub_ovf = (bus.opA[WIDTH-1] != bus.opB[WIDTH-1]) && (w_diff[WIDTH-1] != bus.opA[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      case (bus.ctrlIn)
        OP_ADD:         r_ovf <= w_add_ovf;
        OP_SUB, OP_CMP: r_ovf <= w_sub_ovf;
        default:        r_ovf <= 1'b0;
      endcase
    end
  end

  assign bus.ovfFlag = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Randomized self-checking bench for alu_exec_unit against an
//            arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();
  alu_exec_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        zero;
    logic        dbz;
    logic        ill;
    logic        ovf;
    int          lat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_op;
  exp_t hold;
  int   n_issued = 0;
  int   n_seen = 0;
  bit   in_flight = 0;
  int   cyc = 0;

  function automatic exp_t model(logic [3:0] c, logic [15:0] a, logic [15:0] b);
    exp_t   e;
    longint p;
    int     sa, sb, s;
    e  = '{res: 16'h0, hi: 16'h0, zero: 1'b0, dbz: 1'b0, ill: 1'b0, ovf: 1'b0, lat: 1};
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (c)
      4'b0001, 4'b1100: begin
        e.res  = a + b;
        e.zero = (e.res == 16'h0);
        s      = sa + sb;
        if (c == 4'b0001) e.ovf = (s > 32767) || (s < -32768);
      end
      4'b0010: begin
        e.res  = a - b;
        e.zero = (e.res == 16'h0);
        s      = sa - sb;
        e.ovf  = (s > 32767) || (s < -32768);
      end
      4'b0100: begin
        p      = longint'(a) * longint'(b);
        e.res  = p[15:0];
        e.hi   = p[31:16];
        e.zero = (p == 0);
        e.lat  = 17;
      end
      4'b1000: begin
        if (b == 16'h0) begin
          e.res = 16'hFFFF;
          e.hi  = a;
          e.dbz = 1'b1;
        end else begin
          e.res  = a / b;
          e.hi   = a % b;
          e.zero = (e.res == 16'h0);
          e.lat  = 17;
        end
      end
      4'b1110: begin
        e.res  = b;
        e.zero = (b == 16'h0);
      end
      4'b1111: begin
        e.zero = (a == b);
        s      = sa - sb;
        e.ovf  = (s > 32767) || (s < -32768);
      end
      default: begin
        e.ill  = 1'b1;
        e.zero = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_fields(string tag, exp_t e);
    check({tag, "_result"},    32'(bus.result),    32'(e.res));
    check({tag, "_resultHi"},  32'(bus.resultHi),  32'(e.hi));
    check({tag, "_zeroFlag"},  32'(bus.zeroFlag),  32'(e.zero));
    check({tag, "_divByZero"}, 32'(bus.divByZero), 32'(e.dbz));
    check({tag, "_illegalOp"}, 32'(bus.illegalOp), 32'(e.ill));
`ifdef ALU_OVERFLOW_EN
    check({tag, "_ovfFlag"},   32'(bus.ovfFlag),   32'(e.ovf));
`endif
  endtask

  // Compare process: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 0;
      n_seen    = n_issued;
      hold      = '{res: 16'h0, hi: 16'h0, zero: 1'b0, dbz: 1'b0, ill: 1'b0, ovf: 1'b0, lat: 0};
    end else if (n_seen != n_issued) begin
      n_seen    = n_issued;
      in_flight = 1;
      cyc       = 0;
      check("pre_busy", 32'(bus.busy), 32'd0);
      check("pre_done", 32'(bus.done), 32'd0);
    end else if (in_flight) begin
      cyc++;
      check("flight_busy", 32'(bus.busy), 32'd1);
      check("done_timing", 32'(bus.done), 32'(cyc == exp_op.lat));
      if (bus.done || cyc >= exp_op.lat) begin
        if (bus.done) check_fields("done", exp_op);
        hold      = exp_op;
        in_flight = 0;
      end
    end else begin
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
      check_fields("hold", hold);
    end
  end

  // Caller must be at posedge+#1 of an idle cycle; returns at posedge+#1 of the next idle cycle.
  task automatic issue(logic [3:0] c, logic [15:0] a, logic [15:0] b, bit noise);
    int guard;
    exp_op     = model(c, a, b);
    bus.start  = 1'b1;
    bus.ctrlIn = c;
    bus.opA    = a;
    bus.opB    = b;
    n_issued++;
    @(posedge clk); #1;
    guard = 0;
    do begin
      if (noise) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.ctrlIn = 4'($urandom);
        bus.opA    = 16'($urandom);
        bus.opB    = 16'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end while (in_flight && guard < 40);
    if (in_flight) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done (t=%0t)", $time);
    end
    bus.start = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] codes [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
    if ($urandom_range(0, 7) == 0) return 4'($urandom);
    return codes[$urandom_range(0, 6)];
  endfunction

  initial begin
    bus.start  = 1'b0;
    bus.ctrlIn = 4'h0;
    bus.opA    = 16'h0;
    bus.opB    = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_result", 32'(bus.result), 32'h0);

    issue(4'b0001, 16'hFFFF, 16'h0002, 0);
    check("pin_add", 32'(bus.result), 32'h0001);
    issue(4'b0100, 16'h1234, 16'h0100, 0);
    check("pin_mul_lo", 32'(bus.result),   32'h3400);
    check("pin_mul_hi", 32'(bus.resultHi), 32'h0012);
    issue(4'b1000, 16'd100, 16'd7, 0);
    check("pin_div_q", 32'(bus.result),   32'd14);
    check("pin_div_r", 32'(bus.resultHi), 32'd2);
    issue(4'b1000, 16'd5, 16'd0, 0);
    check("pin_dbz", 32'(bus.divByZero), 32'd1);
    check("pin_dbz_hi", 32'(bus.resultHi), 32'd5);
    issue(4'b0100, 16'd3, 16'd5, 1);
    check("pin_mul_noise", 32'(bus.result), 32'd15);
    issue(4'b0000, 16'h1111, 16'h2222, 0);
    check("pin_illegal", 32'(bus.illegalOp), 32'd1);
    issue(4'b1111, 16'd7, 16'd7, 0);
    check("pin_cmp_zero", 32'(bus.zeroFlag), 32'd1);
`ifdef ALU_OVERFLOW_EN
    issue(4'b0001, 16'h7FFF, 16'h0001, 0);
    check("pin_ovf", 32'(bus.ovfFlag), 32'd1);
`endif

    // Reset in the middle of a divide: aborted, no done, outputs cleared.
    exp_op     = model(4'b1000, 16'd100, 16'd7);
    bus.start  = 1'b1;
    bus.ctrlIn = 4'b1000;
    bus.opA    = 16'd100;
    bus.opB    = 16'd7;
    n_issued++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    issue(4'b0001, 16'd1, 16'd1, 0);
    check("pin_add_after_rst", 32'(bus.result), 32'd2);

    for (int i = 0; i < 80; i++) begin
      issue(pick_op(), pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
